// File: rtl/psum_fifo_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// psum_fifo_ctrl : fill / align / drain sequencer for the partial-sum shift FIFO
// Revision 1.0
// ============================================================================
module psum_fifo_ctrl #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_rows,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             fifo_en,
  output logic             fifo_din_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_ALIGN = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_n, w_n_nxt;
  logic [CNT_W-1:0] w_n_last;
  logic [CNT_W-1:0] w_align_last;

  assign w_n_last     = r_n - c_one;
  assign w_align_last = c_depth - r_n - c_one;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_n     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_n     <= w_n_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_n_nxt       = r_n;
    in_ready      = 1'b0;
    fifo_en       = 1'b0;
    fifo_din_zero = 1'b0;
    out_valid     = 1'b0;
    out_last      = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          // Zero or oversize row counts fall back to a full FIFO.
          w_n_nxt     = (num_rows == '0 || num_rows > c_depth) ? c_depth : num_rows;
          w_cnt_nxt   = '0;
          w_state_nxt = S_FILL;
        end
      end
      S_FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          fifo_en = 1'b1;
          if (r_cnt == w_n_last) begin
            w_cnt_nxt   = '0;
            w_state_nxt = (r_n == c_depth) ? S_DRAIN : S_ALIGN;
          end else begin
            w_cnt_nxt = r_cnt + c_one;
          end
        end
      end
      S_ALIGN: begin
        // Push bubbles until row 0 sits in the output stage.
        fifo_en       = 1'b1;
        fifo_din_zero = 1'b1;
        if (r_cnt == w_align_last) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_DRAIN;
        end else begin
          w_cnt_nxt = r_cnt + c_one;
        end
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        out_last  = (r_cnt == w_n_last);
        if (out_ready) begin
          fifo_en       = 1'b1;
          fifo_din_zero = 1'b1;
          if (r_cnt == w_n_last) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_DONE;
          end else begin
            w_cnt_nxt = r_cnt + c_one;
          end
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

endmodule
`default_nettype wire
